// File: rtl/elevator_request_queue.sv
// Elevator request queue producer: latches call buttons and appends them
// at the tail of the packed level queue. Optional macro: QUEUE_DEDUP_EN.
module elevator_request_queue #(
    parameter  int DEPTH  = 6,
    parameter  int LVL_W  = 2,
    parameter  int TAIL_W = 3,
    localparam int NLVL   = 2 ** LVL_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NLVL-1:0]        btn,
    input  logic                   sub_valid,
    input  logic [DEPTH*LVL_W-1:0] next_queue_sub,
    input  logic [TAIL_W-1:0]      next_tail_sub,
    output logic [DEPTH*LVL_W-1:0] queue,
    output logic [TAIL_W-1:0]      tail,
    output logic [NLVL-1:0]        pending,
    output logic                   full,
    output logic                   empty
);

    localparam logic [TAIL_W-1:0] DEPTH_T = TAIL_W'(DEPTH);

    logic [DEPTH*LVL_W-1:0] queue_q, queue_d;
    logic [TAIL_W-1:0]      tail_q, tail_d;
    logic [NLVL-1:0]        pending_q, pending_d;

    logic [DEPTH*LVL_W-1:0] base_q;
    logic [TAIL_W-1:0]      base_t;
    logic [LVL_W-1:0]       sel;
    logic                   has_cand;
    logic                   dup_hit;
    logic [NLVL-1:0]        clr_mask;

    // Base for this cycle: engine removal result first, clamped to DEPTH
    always_comb begin
        base_q = queue_q;
        base_t = tail_q;
        if (sub_valid) begin
            base_q = next_queue_sub;
            if (next_tail_sub > DEPTH_T) begin
                base_t = DEPTH_T;
            end else begin
                base_t = next_tail_sub;
            end
        end
    end

    // Fixed-priority arbiter: lowest registered pending level wins
    always_comb begin
        sel      = '0;
        has_cand = |pending_q;
        for (int i = NLVL - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel = LVL_W'(i);
            end
        end
    end

`ifdef QUEUE_DEDUP_EN
    // Selected level already waiting in the live part of the base queue
    always_comb begin
        dup_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((TAIL_W'(k) < base_t) &&
                (base_q[k*LVL_W +: LVL_W] == sel)) begin
                dup_hit = 1'b1;
            end
        end
    end
`else
    // Duplicates are queued like any other request
    always_comb begin
        dup_hit = 1'b0;
    end
`endif

    // Append at most one request at the post-removal tail
    always_comb begin
        queue_d  = base_q;
        tail_d   = base_t;
        clr_mask = '0;
        if (has_cand) begin
            if (dup_hit) begin
                clr_mask[sel] = 1'b1;
            end else if (base_t < DEPTH_T) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (TAIL_W'(k) == base_t) begin
                        queue_d[k*LVL_W +: LVL_W] = sel;
                    end
                end
                tail_d        = base_t + TAIL_W'(1);
                clr_mask[sel] = 1'b1;
            end
        end
        pending_d = (pending_q & ~clr_mask) | btn;
    end

    // Queue, tail and pending state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            queue_q   <= '0;
            tail_q    <= '0;
            pending_q <= '0;
        end else begin
            queue_q   <= queue_d;
            tail_q    <= tail_d;
            pending_q <= pending_d;
        end
    end

    assign queue   = queue_q;
    assign tail    = tail_q;
    assign pending = pending_q;
    assign full    = (tail_q == DEPTH_T);
    assign empty   = (tail_q == '0);

endmodule
